// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM single-port SRAM arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbAccRd = 2'd1,
      ArbAccWr = 2'd2,
      ArbDone  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OwnerIf  = 1'b0,
      OwnerMem = 1'b1
   } owner_e;

   localparam logic        SramEnable  = 1'b0;
   localparam logic        SramDisable = 1'b1;
   localparam logic        RstEnable   = 1'b1;
   localparam logic        WriteEnable = 1'b1;
   localparam logic [15:0] ZeroData    = 16'h0000;

   // A write always needs one we_n pulse cycle plus one recovery cycle.
   function automatic logic [2:0] acc_load(input int wait_cycles, input logic is_write);
      if (is_write && wait_cycles == 0) return 3'd1;
      return 3'(wait_cycles);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF, MEM) and SRAM-side signals of the SRAM arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              if_req_i;
   logic [15:0]       if_addr_i;
   logic [15:0]       if_rdata_o;
   logic              if_ready_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [15:0]       mem_addr_i;
   logic [15:0]       mem_wdata_i;
   logic [15:0]       mem_rdata_o;
   logic              mem_ready_o;
   logic              stallreq_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic [15:0]       sram_wdata_o;
   logic              sram_data_oe_o;
   logic [15:0]       sram_rdata_i;
   logic              sram_ce_n_o;
   logic              sram_oe_n_o;
   logic              sram_we_n_o;

   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_rdata_i,
      output if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
             sram_addr_o, sram_wdata_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
   );

   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_rdata_i,
      input  if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
             sram_addr_o, sram_wdata_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and the MEM stage;
// MEM has fixed priority, accesses are never preempted, all SRAM strobes are registered.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 16
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   arb_state_e        state_q;
   owner_e            owner_q;
   logic [2:0]        cnt_q;
   logic              if_ready_q;
   logic              mem_ready_q;
   logic [15:0]       if_rdata_q;
   logic [15:0]       mem_rdata_q;
   logic [ADDR_W-1:0] sram_addr_q;
   logic [15:0]       sram_wdata_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic              data_oe_q;

   logic              owner_mem_d;
   logic              is_wr_d;
   logic [15:0]       addr_d;

   assign owner_mem_d = bus.mem_req_i;
   assign is_wr_d     = bus.mem_req_i && (bus.mem_we_i == WriteEnable);
   assign addr_d      = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q      <= ArbIdle;
         owner_q      <= OwnerIf;
         cnt_q        <= 3'd0;
         if_ready_q   <= 1'b0;
         mem_ready_q  <= 1'b0;
         if_rdata_q   <= ZeroData;
         mem_rdata_q  <= ZeroData;
         sram_addr_q  <= '0;
         sram_wdata_q <= ZeroData;
         ce_n_q       <= SramDisable;
         oe_n_q       <= SramDisable;
         we_n_q       <= SramDisable;
         data_oe_q    <= 1'b0;
      end else begin
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         unique case (state_q)
            ArbIdle: begin
               if (bus.mem_req_i || bus.if_req_i) begin
                  owner_q     <= owner_mem_d ? OwnerMem : OwnerIf;
                  sram_addr_q <= ADDR_W'(addr_d);
                  ce_n_q      <= SramEnable;
                  cnt_q       <= acc_load(WAIT_CYCLES, is_wr_d);
                  if (is_wr_d) begin
                     state_q      <= ArbAccWr;
                     sram_wdata_q <= bus.mem_wdata_i;
                     oe_n_q       <= SramDisable;
                     we_n_q       <= SramEnable;
                     data_oe_q    <= 1'b1;
                  end else begin
                     state_q <= ArbAccRd;
                     oe_n_q  <= SramEnable;
                     we_n_q  <= SramDisable;
                  end
               end
            end
            ArbAccRd: begin
               if (cnt_q == 3'd0) begin
                  state_q <= ArbDone;
                  ce_n_q  <= SramDisable;
                  oe_n_q  <= SramDisable;
                  if (owner_q == OwnerMem) begin
                     mem_rdata_q <= bus.sram_rdata_i;
                     mem_ready_q <= 1'b1;
                  end else begin
                     if_rdata_q <= bus.sram_rdata_i;
                     if_ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            ArbAccWr: begin
               if (cnt_q == 3'd0) begin
                  state_q     <= ArbDone;
                  ce_n_q      <= SramDisable;
                  data_oe_q   <= 1'b0;
                  mem_ready_q <= (owner_q == OwnerMem);
                  if_ready_q  <= (owner_q == OwnerIf);
               end else begin
                  cnt_q <= cnt_q - 3'd1;
                  // Release we_n one cycle early so data is held through recovery.
                  if (cnt_q == 3'd1) we_n_q <= SramDisable;
               end
            end
            ArbDone: state_q <= ArbIdle;
            default: state_q <= ArbIdle;
         endcase
      end
   end

   assign bus.if_ready_o     = if_ready_q;
   assign bus.mem_ready_o    = mem_ready_q;
   assign bus.if_rdata_o     = if_rdata_q;
   assign bus.mem_rdata_o    = mem_rdata_q;
   assign bus.sram_addr_o    = sram_addr_q;
   assign bus.sram_wdata_o   = sram_wdata_q;
   assign bus.sram_ce_n_o    = ce_n_q;
   assign bus.sram_oe_n_o    = oe_n_q;
   assign bus.sram_we_n_o    = we_n_q;
   assign bus.sram_data_oe_o = data_oe_q;
   assign bus.stallreq_o     = (bus.if_req_i & ~if_ready_q) | (bus.mem_req_i & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances with behavioural SRAMs.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(16)) bus1 ();
   mem_arbiter_if #(.ADDR_W(16)) bus0 ();

   mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus1));
   mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   logic [15:0] sram1 [0:65535];
   logic [15:0] sram0 [0:65535];

   assign bus1.sram_rdata_i = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o) ? sram1[bus1.sram_addr_o] : 16'h0000;
   assign bus0.sram_rdata_i = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o) ? sram0[bus0.sram_addr_o] : 16'h0000;

   always @(posedge clk) begin
      if (!bus1.sram_ce_n_o && !bus1.sram_we_n_o && bus1.sram_data_oe_o)
         sram1[bus1.sram_addr_o] = bus1.sram_wdata_o;
      if (!bus0.sram_ce_n_o && !bus0.sram_we_n_o && bus0.sram_data_oe_o)
         sram0[bus0.sram_addr_o] = bus0.sram_wdata_o;
   end

   typedef struct packed {
      logic        if_rdy;
      logic        mem_rdy;
      logic        stall;
      logic        ce_n;
      logic        oe_n;
      logic        we_n;
      logic        doe;
      logic [15:0] if_rd;
      logic [15:0] mem_rd;
      logic [15:0] addr;
      logic [15:0] wd;
   } obs_t;

   typedef struct {
      int          d;
      logic        is_mem;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      int          exp_lat;
      int          exp_oe;
      int          exp_we;
      int          exp_doe;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic obs_t obs(input int d);
      obs_t o;
      if (d == 1)
         o = '{bus1.if_ready_o, bus1.mem_ready_o, bus1.stallreq_o, bus1.sram_ce_n_o, bus1.sram_oe_n_o,
               bus1.sram_we_n_o, bus1.sram_data_oe_o, bus1.if_rdata_o, bus1.mem_rdata_o,
               bus1.sram_addr_o, bus1.sram_wdata_o};
      else
         o = '{bus0.if_ready_o, bus0.mem_ready_o, bus0.stallreq_o, bus0.sram_ce_n_o, bus0.sram_oe_n_o,
               bus0.sram_we_n_o, bus0.sram_data_oe_o, bus0.if_rdata_o, bus0.mem_rdata_o,
               bus0.sram_addr_o, bus0.sram_wdata_o};
      return o;
   endfunction

   task automatic drive(input int d, input logic ireq, input logic [15:0] iaddr,
                        input logic mreq, input logic mwe, input logic [15:0] maddr, input logic [15:0] mwd);
      if (d == 1) begin
         bus1.if_req_i = ireq;  bus1.if_addr_i = iaddr;
         bus1.mem_req_i = mreq; bus1.mem_we_i = mwe; bus1.mem_addr_i = maddr; bus1.mem_wdata_i = mwd;
      end else begin
         bus0.if_req_i = ireq;  bus0.if_addr_i = iaddr;
         bus0.mem_req_i = mreq; bus0.mem_we_i = mwe; bus0.mem_addr_i = maddr; bus0.mem_wdata_i = mwd;
      end
   endtask

   task automatic check_reset(input string tag, input int d);
      obs_t o;
      o = obs(d);
      chk({tag, "_strobes"}, 32'({o.ce_n, o.oe_n, o.we_n, o.doe}), 32'b1110);
      chk({tag, "_ready"},   32'({o.if_rdy, o.mem_rdy}), 32'b00);
      chk({tag, "_rdata"},   {o.if_rd, o.mem_rd}, 32'h0000_0000);
      chk({tag, "_addr_wd"}, {o.addr, o.wd}, 32'h0000_0000);
   endtask

   // One complete transaction; strobe activity is counted per sampled cycle.
   task automatic run_txn(input vec_t v, output int lat, output logic [15:0] rd,
                          output int n_oe, output int n_we, output int n_doe,
                          output int n_other, output int stall_bad);
      obs_t o;
      logic rdy;
      @(negedge clk);
      if (v.is_mem) drive(v.d, 1'b0, 16'h0, 1'b1, v.we, v.addr, v.wd);
      else          drive(v.d, 1'b1, v.addr, 1'b0, 1'b0, 16'h0, 16'h0);
      lat = -1; n_oe = 0; n_we = 0; n_doe = 0; n_other = 0; stall_bad = 0;
      o = obs(v.d);
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         o = obs(v.d);
         if (!o.oe_n) n_oe++;
         if (!o.we_n) n_we++;
         if (o.doe)   n_doe++;
         if (v.is_mem ? o.if_rdy : o.mem_rdy) n_other++;
         rdy = v.is_mem ? o.mem_rdy : o.if_rdy;
         if (rdy) begin
            if (o.stall) stall_bad++;
            lat = c;
            break;
         end else if (!o.stall) stall_bad++;
      end
      rd = v.is_mem ? o.mem_rd : o.if_rd;
      drive(v.d, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   vec_t vecs [$];

   initial begin
      int lat, n_oe, n_we, n_doe, n_other, stall_bad, t;
      logic [15:0] rd;
      logic got, early;
      obs_t o;

      sram1[16'h0040] = 16'h6A05;
      sram1[16'h0010] = 16'h1234;
      sram0[16'h0007] = 16'h7777;

      //            d  mem we addr      wdata     exp_rd    lat oe we doe
      vecs.push_back('{1, 0, 0, 16'h0040, 16'h0000, 16'h6A05, 3, 2, 0, 0});
      vecs.push_back('{1, 1, 1, 16'h8001, 16'hBEEF, 16'h0000, 3, 0, 1, 2});
      vecs.push_back('{1, 0, 0, 16'h8001, 16'h0000, 16'hBEEF, 3, 2, 0, 0});
      vecs.push_back('{1, 1, 0, 16'h0010, 16'h0000, 16'h1234, 3, 2, 0, 0});
      vecs.push_back('{1, 1, 1, 16'h0020, 16'h5555, 16'h1234, 3, 0, 1, 2});
      vecs.push_back('{1, 1, 0, 16'h0020, 16'h0000, 16'h5555, 3, 2, 0, 0});
      vecs.push_back('{1, 0, 0, 16'h0010, 16'h0000, 16'h1234, 3, 2, 0, 0});
      vecs.push_back('{0, 0, 0, 16'h0007, 16'h0000, 16'h7777, 2, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 16'h0008, 16'h8888, 16'h0000, 3, 0, 1, 2});
      vecs.push_back('{0, 1, 0, 16'h0008, 16'h0000, 16'h8888, 2, 1, 0, 0});
      vecs.push_back('{0, 0, 0, 16'h0008, 16'h0000, 16'h8888, 2, 1, 0, 0});

      rst = 1'b1;
      drive(1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      check_reset("reset_w1", 1);
      check_reset("reset_w0", 0);
      chk("reset_stall", 32'(bus1.stallreq_o), 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_txn(vecs[i], lat, rd, n_oe, n_we, n_doe, n_other, stall_bad);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
         chk($sformatf("vec%0d_oe_cycles", i), 32'(n_oe), 32'(vecs[i].exp_oe));
         chk($sformatf("vec%0d_we_cycles", i), 32'(n_we), 32'(vecs[i].exp_we));
         chk($sformatf("vec%0d_doe_cycles", i), 32'(n_doe), 32'(vecs[i].exp_doe));
         chk($sformatf("vec%0d_other_ready", i), 32'(n_other), 32'd0);
         chk($sformatf("vec%0d_stall", i), 32'(stall_bad), 32'd0);
      end

      // Simultaneous requests: MEM first, IF four cycles after mem_ready.
      @(negedge clk);
      drive(1, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0010, 16'h0);
      t = 0; got = 1'b0; early = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         o = obs(1);
         if (o.if_rdy) early = 1'b1;
         if (o.mem_rdy) begin got = 1'b1; t = c; break; end
      end
      chk("simul_mem_ready", 32'(got), 32'd1);
      chk("simul_mem_latency", 32'(t), 32'd3);
      chk("simul_if_not_first", 32'(early), 32'd0);
      chk("simul_mem_rdata", 32'(o.mem_rd), 32'h1234);
      drive(1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
      t = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         o = obs(1);
         if (o.if_rdy) begin t = c; break; end
      end
      chk("simul_if_gap", 32'(t), 32'd4);
      chk("simul_if_rdata", 32'(o.if_rd), 32'h6A05);
      drive(1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // MEM request arriving during an IF access waits for the next IDLE.
      @(negedge clk);
      drive(1, 1'b1, 16'h8001, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      drive(1, 1'b1, 16'h8001, 1'b1, 1'b1, 16'h0030, 16'h0F0F);
      t = 1; early = 1'b0;
      for (int c = 2; c <= 32; c++) begin
         @(negedge clk);
         o = obs(1);
         if (o.mem_rdy) early = 1'b1;
         if (o.if_rdy) begin t = c; break; end
      end
      chk("preempt_if_latency", 32'(t), 32'd3);
      chk("preempt_mem_not_first", 32'(early), 32'd0);
      chk("preempt_if_rdata", 32'(o.if_rd), 32'hBEEF);
      drive(1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'h0F0F);
      t = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         if (bus1.mem_ready_o) begin t = c; break; end
      end
      chk("preempt_mem_gap", 32'(t), 32'd4);
      chk("preempt_mem_written", 32'(sram1[16'h0030]), 32'h0F0F);
      drive(1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Reset in the write-recovery cycle aborts the access.
      @(negedge clk);
      drive(1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0050, 16'hAAAA);
      @(negedge clk);
      chk("abort_c1_we_n", 32'(bus1.sram_we_n_o), 32'd0);
      @(negedge clk);
      chk("abort_c2_we_n_doe", 32'({bus1.sram_we_n_o, bus1.sram_data_oe_o}), 32'b11);
      rst = 1'b1;
      drive(1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      check_reset("abort", 1);
      rst = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus1.mem_ready_o || bus1.if_ready_o) got = 1'b1;
      end
      chk("abort_no_ready", 32'(got), 32'd0);

      run_txn('{1, 0, 0, 16'h0040, 16'h0000, 16'h6A05, 3, 2, 0, 0}, lat, rd, n_oe, n_we, n_doe, n_other, stall_bad);
      chk("post_reset_latency", 32'(lat), 32'd3);
      chk("post_reset_rdata", 32'(rd), 32'h6A05);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
